cache_ram_responder: RTL
========================

CACHE_RAM_RESPONDER -- requirements
Module: cache_ram_responder

Interface
REQ-001 The block SHALL have parameter ramWidth, default 8, data word width in bits.
REQ-002 The block SHALL have parameter addrWidth, default 8, address width in bits; the memory depth SHALL be 2**addrWidth words.
REQ-003 The block SHALL have parameter latency, default 2, the number of cycles from request capture to ack; the legal range SHALL be 1..15.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 clr  input  1  reset; synchronous, active-high.
REQ-006 syn  input  1  request strobe from the cache; level-held until ack is seen.
REQ-007 readWrite  input  1  operation select: 0 = read, 1 = write (write-back of a dirty line).
REQ-008 addr  input  addrWidth  word address, stable while syn is high.
REQ-009 dataIn  input  ramWidth  write data, stable while syn is high.
REQ-010 ack  output  1  request completed; stays high until syn falls.
REQ-011 dataOut  output  ramWidth  read data, valid while ack is high after a read.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL implement a four-phase handshake: syn up, ack up, syn down, ack down.
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, ACK.
REQ-015 In IDLE with syn=1, the block SHALL register addr, dataIn and readWrite, load the latency counter with latency-1, and enter WAIT.
REQ-016 In WAIT, the counter SHALL decrement by 1 per cycle; when the counter is 0 and syn=1, the block SHALL perform the access and enter ACK with ack=1 on that same edge.
REQ-017 Total latency SHALL be exactly latency cycles from the capture edge to the edge that raises ack (latency=2: capture at edge N, ack high after edge N+2).
REQ-018 A write SHALL update mem[latched addr] with the latched data on the ack-raising edge; dataOut SHALL be unchanged.
REQ-019 A read SHALL load dataOut with mem[latched addr] on the ack-raising edge.
REQ-020 Address and data SHALL come only from the captured registers; changes on addr, dataIn or readWrite after capture SHALL be ignored.
REQ-021 In ACK, ack SHALL stay 1 while syn=1; when syn=0 the block SHALL clear ack and return to IDLE; a new request SHALL NOT be captured on that same edge.
REQ-022 If syn falls during WAIT, the block SHALL abort: no memory write, dataOut unchanged, return to IDLE, ack stays 0.
REQ-023 syn held high across consecutive requests SHALL NOT cause a second capture until ack has dropped and IDLE is re-entered.
REQ-024 dataOut SHALL hold its last read value through later writes and IDLE periods.
REQ-025 Accesses at address 0 and at address 2**addrWidth-1 SHALL behave identically to any other address; there SHALL be no wrap or aliasing.

Reset
REQ-026 With clr=1 at a rising edge, the block SHALL force state=IDLE, ack=0, busy=0, dataOut=0 and counter=0, and SHALL clear the latched request registers; clr SHALL take priority over all other inputs.
REQ-027 Reset during WAIT SHALL cancel the pending write; memory contents SHALL NOT be altered by reset.
REQ-028 Memory contents SHALL be undefined after power-up, and reset SHALL NOT initialise the memory array.

Structure
REQ-029 The FSM state encoding and the default widths (ramWidth, addrWidth) SHALL be defined in the shared memory-interface package also used by the cache.
REQ-030 The storage array SHALL be a sub-module, ram_array: single port, synchronous write, registered read, addrWidth by ramWidth; the responder SHALL contain only the FSM, the counter and the latches.

Verification
REQ-031 Write then read: write 0xA5 to address 0x3C; after ack drops, read 0x3C -> dataOut=0xA5 with ack high, exactly 2 cycles after capture.
REQ-032 Address boundaries: write 0x11 to 0x00 and 0xEE to 0xFF, then read both -> 0x11 and 0xEE respectively; no other address is changed.
REQ-033 Abort: issue a write of 0x77 to 0x10, drop syn one cycle after capture; then read 0x10 -> the prior value, with no ack during the aborted request.
REQ-034 Held syn: keep syn high 10 cycles past ack -> ack stays 1 and busy stays 1 throughout; exactly one access is performed, and ack falls on the first edge after syn=0.
REQ-035 Reset mid-operation: assert clr during WAIT of a write of 0x5A to 0x20 -> next cycle ack=0, busy=0, dataOut=0; a later read of 0x20 does not return 0x5A.
REQ-036 latency=1 and latency=15 builds: ack rises exactly 1 and 15 cycles after capture respectively.

Source files
------------

// File: rtl/cache_ram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_ram_responder_pkg
// Description : Shared memory-interface definitions for the cache and its RAM
//               responder. Holds the default word and address widths, the
//               responder FSM state encoding and the latency counter helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_ram_responder_pkg;

  // Default geometry of the backing RAM, also used by the cache side.
  localparam int RAM_WIDTH_DEF  = 8;
  localparam int ADDR_WIDTH_DEF = 8;

  // Default request-to-ack latency and the supported latency range.
  localparam int LATENCY_DEF = 2;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;

  // The latency counter only ever holds latency-1, so 4 bits cover 0..14.
  localparam int LAT_CNT_W = 4;
  typedef logic [LAT_CNT_W-1:0] lat_cnt_t;

  localparam lat_cnt_t LAT_CNT_ZERO = lat_cnt_t'(0);
  localparam lat_cnt_t LAT_CNT_ONE  = lat_cnt_t'(1);

  // Responder FSM state encoding. Kept as plain vector constants so that
  // older cache models that compare raw state codes keep working.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Operation select values on readWrite.
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Value loaded into the latency counter at capture. Out-of-range latency
  // settings are pinned to the nearest legal value so the counter can never
  // be loaded with something it cannot count down from.
  function automatic lat_cnt_t lat_load(input int lat);
    int lat_c;
    lat_c = lat;
    if (lat_c < LATENCY_MIN) begin
      lat_c = LATENCY_MIN;
    end
    if (lat_c > LATENCY_MAX) begin
      lat_c = LATENCY_MAX;
    end
    return lat_cnt_t'(lat_c - 1);
  endfunction

endpackage : cache_ram_responder_pkg
`default_nettype wire

// File: rtl/cache_ram_responder_ram_array.sv
`default_nettype none
// ============================================================================
// Module      : ram_array
// Description : Single-port storage array, 2**addrWidth words of ramWidth
//               bits. Synchronous write, registered read. Only the read-data
//               register is cleared by clr; the array itself is never
//               initialised, so its power-up contents are undefined.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_array
  import cache_ram_responder_pkg::*;
#(
  parameter int ramWidth  = RAM_WIDTH_DEF,
  parameter int addrWidth = ADDR_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [addrWidth-1:0] addr_i,
  input  logic [ramWidth-1:0]  wdata_i,
  output logic [ramWidth-1:0]  rdata_o
);

  localparam int DEPTH = 2 ** addrWidth;

  logic [ramWidth-1:0] mem_q [0:DEPTH-1];
  logic [ramWidth-1:0] rdata_q;

  // Array write: no reset term, so clr never disturbs stored contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Registered read port: holds its value until the next read or clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : ram_array
`default_nettype wire

// File: rtl/cache_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : cache_ram_responder
// Description : RAM responder for the cache miss/write-back path. Captures a
//               request on a four-phase syn/ack handshake, waits a fixed
//               number of cycles, performs one access on the ram_array and
//               holds ack until the cache withdraws syn.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ram_responder
  import cache_ram_responder_pkg::*;
#(
  parameter int ramWidth  = RAM_WIDTH_DEF,
  parameter int addrWidth = ADDR_WIDTH_DEF,
  parameter int latency   = LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 syn,
  input  logic                 readWrite,
  input  logic [addrWidth-1:0] addr,
  input  logic [ramWidth-1:0]  dataIn,
  output logic                 ack,
  output logic [ramWidth-1:0]  dataOut,
  output logic                 busy
);

  localparam lat_cnt_t LAT_LOAD = lat_load(latency);

  logic [1:0]           state_q, state_d;
  lat_cnt_t             cnt_q, cnt_d;
  logic [addrWidth-1:0] addr_q, addr_d;
  logic [ramWidth-1:0]  data_q, data_d;
  logic                 rw_q, rw_d;
  logic                 access;
  logic                 ram_we;
  logic                 ram_re;

  // Next-state logic: capture in IDLE, count down in WAIT, hold in ACK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (syn) begin
          addr_d  = addr;
          data_d  = dataIn;
          rw_d    = readWrite;
          cnt_d   = LAT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!syn) begin
          // Cache withdrew the request early: drop it without an access.
          state_d = ST_IDLE;
        end else if (cnt_q == LAT_CNT_ZERO) begin
          access  = 1'b1;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - LAT_CNT_ONE;
        end
      end
      ST_ACK: begin
        // Leaving ACK goes through IDLE, so a held syn cannot re-capture
        // on the same edge that drops ack.
        if (!syn) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and request latches; clr overrides everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= LAT_CNT_ZERO;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= OP_READ;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
    end
  end

  // The access is qualified by clr so a reset edge can never commit a write.
  assign ram_we = access & (rw_q == OP_WRITE) & ~clr;
  assign ram_re = access & (rw_q == OP_READ)  & ~clr;

  ram_array #(
    .ramWidth  (ramWidth),
    .addrWidth (addrWidth)
  ) u_ram_array (
    .clk     (clk),
    .clr     (clr),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (addr_q),
    .wdata_i (data_q),
    .rdata_o (dataOut)
  );

  assign ack  = (state_q == ST_ACK);
  assign busy = (state_q != ST_IDLE);

endmodule : cache_ram_responder
`default_nettype wire
